// File: rtl/time_display_pkg.sv
// time_display_pkg: segment codes, digit positions and field limits shared by the display driver
package time_display_pkg;
  localparam int NUM_DIGITS = 8;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DIGITS [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  localparam logic [2:0] DIG_CEN_U = 3'd0;
  localparam logic [2:0] DIG_CEN_T = 3'd1;
  localparam logic [2:0] DIG_SEC_U = 3'd2;
  localparam logic [2:0] DIG_SEC_T = 3'd3;
  localparam logic [2:0] DIG_MIN_U = 3'd4;
  localparam logic [2:0] DIG_MIN_T = 3'd5;
  localparam logic [2:0] DIG_HOUR_U = 3'd6;
  localparam logic [2:0] DIG_HOUR_T = 3'd7;
  localparam logic [6:0] LIM_HOURS = 7'd23;
  localparam logic [6:0] LIM_MINUTES = 7'd59;
  localparam logic [6:0] LIM_SECONDS = 7'd59;
  localparam logic [6:0] LIM_CENTIS = 7'd99;
  function automatic logic [6:0] seg_of(input logic [6:0] d);
    return d < 7'd10 ? SEG_DIGITS[d[3:0]] : SEG_DASH;
  endfunction
endpackage

// File: rtl/seg7_field_encoder.sv
// seg7_field_encoder: splits one time field into tens/units segment codes, dashing both when over limit
module seg7_field_encoder
  import time_display_pkg::*;
(
  input  logic [6:0] value,
  input  logic [6:0] limit,
  output logic [6:0] tens,
  output logic [6:0] units
);
  logic over;
  assign over = value > limit;
  assign tens = over ? SEG_DASH : seg_of(value / 7'd10);
  assign units = over ? SEG_DASH : seg_of(value % 7'd10);
endmodule

// File: rtl/time_display_driver.sv
// time_display_driver: scans an 8-digit HH MM SS CC display from a per-frame snapshot of the
// time inputs and drives an alarm buzzer that also blanks the display during its off-phases.
module time_display_driver
  import time_display_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter int BEEP_HALF = 50
) (
  input  logic       clockSignal,
  input  logic       startOrStop,
  input  logic [4:0] hoursIn,
  input  logic [5:0] minutesIn,
  input  logic [5:0] secondsIn,
  input  logic [6:0] centisIn,
  input  logic       ringIn,
  output logic [6:0] seg,
  output logic [7:0] digitEnable,
  output logic       dp,
  output logic       buzzer,
  output logic       frameDone
);
  logic [7:0] pre;
  logic [2:0] idx;
  logic [8:0] beep;
  logic [4:0] hrs_q, hrs;
  logic [5:0] min_q, mins, sec_q, secs;
  logic [6:0] cen_q, cens;
  logic frame_start, pre_last, beep_on;
  logic [6:0] ht, hu, mt, mu, st, su, ct, cu, seg_d;
  assign frame_start = pre == 8'd0 && idx == 3'd0;
  assign pre_last = pre == 8'(SCAN_DIV - 1);
  assign beep_on = beep < 9'(BEEP_HALF);
  // the capture edge shows digit 0 straight from the inputs so the new snapshot is used immediately
  assign hrs = frame_start ? hoursIn : hrs_q;
  assign mins = frame_start ? minutesIn : min_q;
  assign secs = frame_start ? secondsIn : sec_q;
  assign cens = frame_start ? centisIn : cen_q;
  seg7_field_encoder u_hrs (.value({2'b00, hrs}), .limit(LIM_HOURS), .tens(ht), .units(hu));
  seg7_field_encoder u_min (.value({1'b0, mins}), .limit(LIM_MINUTES), .tens(mt), .units(mu));
  seg7_field_encoder u_sec (.value({1'b0, secs}), .limit(LIM_SECONDS), .tens(st), .units(su));
  seg7_field_encoder u_cen (.value(cens), .limit(LIM_CENTIS), .tens(ct), .units(cu));
  always_comb
    case (idx)
      DIG_CEN_U: seg_d = cu;
      DIG_CEN_T: seg_d = ct;
      DIG_SEC_U: seg_d = su;
      DIG_SEC_T: seg_d = st;
      DIG_MIN_U: seg_d = mu;
      DIG_MIN_T: seg_d = mt;
      DIG_HOUR_U: seg_d = hu;
      default: seg_d = hrs < 5'd10 ? SEG_BLANK : ht;
    endcase
  always_ff @(posedge clockSignal or posedge startOrStop)
    if (startOrStop) begin
      pre <= '0;
      idx <= '0;
      beep <= '0;
      hrs_q <= '0;
      min_q <= '0;
      sec_q <= '0;
      cen_q <= '0;
      seg <= '0;
      digitEnable <= '0;
      dp <= 1'b0;
      buzzer <= 1'b0;
      frameDone <= 1'b0;
    end else begin
      pre <= pre_last ? 8'd0 : pre + 8'd1;
      idx <= pre_last ? idx + 3'd1 : idx;
      beep <= !ringIn || beep == 9'(2 * BEEP_HALF - 1) ? 9'd0 : beep + 9'd1;
      hrs_q <= hrs;
      min_q <= mins;
      sec_q <= secs;
      cen_q <= cens;
      seg <= seg_d;
      digitEnable <= ringIn && !beep_on ? 8'd0 : 8'd1 << idx;
      dp <= idx == DIG_SEC_U || idx == DIG_MIN_U || idx == DIG_HOUR_U;
      buzzer <= ringIn && beep_on;
      frameDone <= frame_start;
    end
endmodule

// File: tb/tb_time_display_driver.sv
// tb_time_display_driver: table vectors, corner-case sequences and random stimulus against a cycle-count model
module tb_time_display_driver;
  localparam int SD = 4;
  localparam int BH = 50;
  localparam int FRAME = 8 * SD;
  localparam logic [6:0] CODES [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  typedef struct {
    int h, m, s, c;
    logic [55:0] exp;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, ring = 1'b0;
  logic [4:0] h;
  logic [5:0] m, s;
  logic [6:0] c;
  logic [6:0] seg, seg1;
  logic [7:0] de, de1;
  logic dp, dp1, bz, bz1, fd, fd1;
  int total = 0, bad = 0;
  int e, rc, ch, cm, cs, cc;
  logic [6:0] exp_seg;
  logic [7:0] exp_de;
  logic exp_dp, exp_bz, exp_fd;
  vec_t tbl [5];
  time_display_driver dut (
    .clockSignal(clk), .startOrStop(rst), .hoursIn(h), .minutesIn(m), .secondsIn(s), .centisIn(c),
    .ringIn(ring), .seg(seg), .digitEnable(de), .dp(dp), .buzzer(bz), .frameDone(fd)
  );
  time_display_driver #(.SCAN_DIV(1), .BEEP_HALF(3)) dut1 (
    .clockSignal(clk), .startOrStop(rst), .hoursIn(h), .minutesIn(m), .secondsIn(s), .centisIn(c),
    .ringIn(1'b0), .seg(seg1), .digitEnable(de1), .dp(dp1), .buzzer(bz1), .frameDone(fd1)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // d: 0 = centis units .. 7 = hours tens
  function automatic logic [6:0] mseg(input int d, input int hv, input int mv, input int sv, input int cv);
    int v, lim, dig;
    v = d < 2 ? cv : d < 4 ? sv : d < 6 ? mv : hv;
    lim = d < 2 ? 99 : d < 6 ? 59 : 23;
    if (v > lim) return 7'h40;
    dig = d % 2 == 1 ? v / 10 : v % 10;
    if (d == 7 && dig == 0) return 7'h00;
    return CODES[dig];
  endfunction
  // reference: e = edges since release, rc = consecutive high ring samples before this edge
  always @(posedge clk or posedge rst)
    if (rst) begin
      e <= 0; rc <= 0; ch <= 0; cm <= 0; cs <= 0; cc <= 0;
      exp_seg <= 0; exp_de <= 0; exp_dp <= 0; exp_bz <= 0; exp_fd <= 0;
    end else begin
      e <= e + 1;
      rc <= ring ? rc + 1 : 0;
      if (e % FRAME == 0) begin ch <= h; cm <= m; cs <= s; cc <= c; end
      exp_seg <= e % FRAME == 0 ? mseg(e / SD % 8, h, m, s, c) : mseg(e / SD % 8, ch, cm, cs, cc);
      exp_de <= ring && rc / BH % 2 == 1 ? 8'h00 : 8'(1 << (e / SD % 8));
      exp_dp <= (e / SD % 8) inside {2, 4, 6};
      exp_bz <= ring && rc / BH % 2 == 0;
      exp_fd <= e % FRAME == 0;
    end
  always @(posedge clk) begin
    #1;
    check("model_seg", seg, exp_seg);
    check("model_de", de, exp_de);
    check("model_dp", dp, exp_dp);
    check("model_buzzer", bz, exp_bz);
    check("model_frameDone", fd, exp_fd);
  end
  task automatic wait_fd();
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (!fd && n < 200);
    check("wait_frameDone", fd, 1);
  endtask
  task automatic wait_de(input logic [7:0] v);
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (de != v && n < 300);
    check("wait_digitEnable", de, v);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    tbl[0] = '{12, 34, 56, 78, {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F}};
    tbl[1] = '{5, 60, 7, 99, {7'h00, 7'h6D, 7'h40, 7'h40, 7'h3F, 7'h07, 7'h6F, 7'h6F}};
    tbl[2] = '{23, 59, 59, 0, {7'h5B, 7'h4F, 7'h6D, 7'h6F, 7'h6D, 7'h6F, 7'h3F, 7'h3F}};
    tbl[3] = '{24, 0, 60, 100, {7'h40, 7'h40, 7'h3F, 7'h3F, 7'h40, 7'h40, 7'h40, 7'h40}};
    tbl[4] = '{9, 5, 10, 1, {7'h00, 7'h6F, 7'h3F, 7'h6D, 7'h06, 7'h3F, 7'h3F, 7'h06}};
    h = 12; m = 34; s = 56; c = 78;
    repeat (3) @(negedge clk);
    check("rst_seg", seg, 0);
    check("rst_de", de, 0);
    check("rst_dp", dp, 0);
    check("rst_buzzer", bz, 0);
    check("rst_frameDone", fd, 0);
    rst = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      check("div1_de", de1, 1 << (k % 8));
      check("div1_seg", seg1, tbl[0].exp[(k % 8) * 7 +: 7]);
      check("div1_dp", dp1, (k % 8) inside {2, 4, 6});
      check("div1_frameDone", fd1, k % 8 == 0);
      check("div1_buzzer", bz1, 0);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      h = 5'(tbl[i].h); m = 6'(tbl[i].m); s = 6'(tbl[i].s); c = 7'(tbl[i].c);
      wait_fd();
      for (int d = 0; d < 8; d++) begin
        check("tbl_seg", seg, tbl[i].exp[d * 7 +: 7]);
        check("tbl_de", de, 1 << d);
        check("tbl_dp", dp, d inside {2, 4, 6});
        repeat (SD) @(posedge clk);
        #1;
      end
    end
    wait_fd();
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!fd && n < 100);
    check("frame_period", n, FRAME);
    @(negedge clk);
    h = 12; m = 3; s = 56; c = 78;
    wait_fd();
    wait_de(8'h08);
    @(negedge clk) m = 4;
    wait_de(8'h10);
    check("hold_old_min", seg, 7'h4F);
    wait_fd();
    wait_de(8'h10);
    check("new_min", seg, 7'h66);
    @(negedge clk) ring = 1'b1;
    for (int k = 0; k < 250; k++) begin
      @(posedge clk); #1;
      check("ring_buzzer", bz, k / 50 % 2 == 0);
      check("ring_de_blank", de == 0, k / 50 % 2 == 1);
    end
    @(negedge clk) ring = 1'b0;
    @(posedge clk); #1;
    check("ring_off_buzzer", bz, 0);
    check("ring_off_de", de != 0, 1);
    wait_de(8'h20);
    #2 rst = 1'b1;
    #1;
    check("async_seg", seg, 0);
    check("async_de", de, 0);
    check("async_dp", dp, 0);
    check("async_frameDone", fd, 0);
    @(negedge clk) c = 42;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("rel_frameDone", fd, 1);
    check("rel_de", de, 8'h01);
    check("rel_seg", seg, 7'h5B);
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) begin
        h = 5'($urandom_range(0, 31));
        m = 6'($urandom_range(0, 63));
        s = 6'($urandom_range(0, 63));
        c = 7'($urandom_range(0, 127));
      end
      if ($urandom_range(0, 59) == 0) ring = ~ring;
      if ($urandom_range(0, 399) == 0) begin
        #($urandom_range(1, 2)) rst = 1'b1;
        #2 rst = 1'b0;
      end
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
